// File: rtl/dcache_arbiter_if.sv
// Request, response and cache-side signal bundle for the two-port data cache arbiter.
// The slave modport is the arbiter; the master modport is requesters plus cache.
interface dcache_arbiter_if;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_write;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_id;
  logic             rsp_err;
  logic [31:0]      rsp_data;
  logic [31:0]      cache_addr;
  logic [31:0]      cache_data_in;
  logic [4:0]       cache_uop;
  logic [31:0]      cache_data_out;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, cache_data_out,
    output req_ready, rsp_valid, rsp_id, rsp_err, rsp_data,
           cache_addr, cache_data_in, cache_uop
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, cache_data_out,
    input  req_ready, rsp_valid, rsp_id, rsp_err, rsp_data,
           cache_addr, cache_data_in, cache_uop
  );
endinterface

// File: rtl/dcache_arbiter.sv
// Round-robin arbiter and 3-cycle sequencer in front of the execute-stage data cache.
// Grants one load/store at a time and returns a tagged one-cycle response pulse.
module dcache_arbiter #(
  parameter logic [4:0]  STR_UOP = 5'b01001,
  parameter logic [4:0]  LDR_UOP = 5'b01010,
  parameter logic [4:0]  NOP_UOP = 5'b00000,
  parameter int unsigned DEPTH   = 32
) (
  input logic              clock,
  input logic              reset,
  dcache_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        id_q, id_d;
  logic        err_q, err_d;
  logic        write_q, write_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [31:0] cache_addr_q, cache_addr_d;
  logic [31:0] cache_data_in_q, cache_data_in_d;
  logic [4:0]  cache_uop_q, cache_uop_d;
  logic [31:0] hold_q;

  logic [1:0]  grant;
  logic        gnt_id;
  logic        in_range;

  // When both are valid, prefer the requester that was not granted last.
  always_comb begin
    grant = 2'b00;
    if (state_q == StIdle) begin
      unique case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign gnt_id   = grant[1];
  assign in_range = bus.req_addr[gnt_id] < DEPTH;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    id_d            = id_q;
    err_d           = err_q;
    write_d         = write_q;
    rsp_valid_d     = 1'b0;
    rsp_id_d        = rsp_id_q;
    rsp_err_d       = rsp_err_q;
    rsp_data_d      = rsp_data_q;
    cache_addr_d    = cache_addr_q;
    cache_data_in_d = cache_data_in_q;
    cache_uop_d     = cache_uop_q;
    unique case (state_q)
      StIdle: begin
        if (|grant) begin
          state_d         = StIssue;
          last_grant_d    = gnt_id;
          id_d            = gnt_id;
          write_d         = bus.req_write[gnt_id];
          err_d           = !in_range;
          cache_addr_d    = bus.req_addr[gnt_id];
          cache_data_in_d = bus.req_wdata[gnt_id];
          // Out-of-range requests never reach the cache.
          if (!in_range)                  cache_uop_d = NOP_UOP;
          else if (bus.req_write[gnt_id]) cache_uop_d = STR_UOP;
          else                            cache_uop_d = LDR_UOP;
        end
      end
      StIssue: begin
        cache_uop_d = NOP_UOP;
        state_d     = StCapture;
      end
      StCapture: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = err_q;
        rsp_data_d  = (!write_q && !err_q) ? hold_q : 32'h0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      last_grant_q    <= 1'b1;
      id_q            <= 1'b0;
      err_q           <= 1'b0;
      write_q         <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_data_q      <= 32'h0;
      cache_addr_q    <= 32'h0;
      cache_data_in_q <= 32'h0;
      cache_uop_q     <= NOP_UOP;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      id_q            <= id_d;
      err_q           <= err_d;
      write_q         <= write_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_id_q        <= rsp_id_d;
      rsp_err_q       <= rsp_err_d;
      rsp_data_q      <= rsp_data_d;
      cache_addr_q    <= cache_addr_d;
      cache_data_in_q <= cache_data_in_d;
      cache_uop_q     <= cache_uop_d;
    end
  end

  // The cache clears data_out at the falling edge after a load; grab it just before.
  always_ff @(negedge clock) begin
    hold_q <= bus.cache_data_out;
  end

  assign bus.req_ready     = grant;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.cache_addr    = cache_addr_q;
  assign bus.cache_data_in = cache_data_in_q;
  assign bus.cache_uop     = cache_uop_q;

endmodule

// File: doc/dcache_arbiter.md
Name: dcache_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the execute-stage data cache (32 words x 32 bit, word-indexed, 5-bit address).
- Accepts load/store requests over valid/ready, grants one at a time round-robin, and drives the cache's addr/data_in/uop inputs.
- Captures load data and returns a one-cycle response pulse tagged with the requester ID.
- Requester 0 is the load/store unit; requester 1 is the debug/fill port.

Parameters:
- STR_UOP, 5'b01001, uop code the cache executes as a store.
- LDR_UOP, 5'b01010, uop code the cache executes as a load.
- NOP_UOP, 5'b00000, idle uop; the cache ignores it (data_out forced to 0).
- DEPTH, 32, cache words; legal addresses are 0..DEPTH-1.

Ports:
- clock  in  1  single clock, rising-edge logic plus one falling-edge capture register
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-requester request valid; index = requester ID
- req_ready  out  2  per-requester accept; at most one bit set
- req_write  in  2  1 = store, 0 = load
- req_addr  in  2x32  word address per requester
- req_wdata  in  2x32  store data per requester
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  1  requester ID of the response
- rsp_err  out  1  address out of range; cache not accessed
- rsp_data  out  32  load data; 0 for stores and errors
- cache_addr  out  32  to cache addr
- cache_data_in  out  32  to cache data_in
- cache_uop  out  5  to cache uop
- cache_data_out  in  32  from cache data_out

Behaviour:
- Reset (rising edge with reset=1):
  - state=IDLE, last_grant=1 (requester 0 has first priority), req_ready=0.
  - rsp_valid=0, rsp_id=0, rsp_err=0, rsp_data=0.
  - cache_uop=NOP_UOP, cache_addr=0, cache_data_in=0.
  - Reset mid-transaction aborts it: no response is issued, and cache_uop is NOP from the next cycle. A store already presented to the cache before the reset edge may still complete at the following falling edge.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - req_ready is combinational and equals the grant: the requester with req_valid set, preferring the one not equal to last_grant when both are valid.
  - On a rising edge with valid&ready: latch the request, set last_grant to that ID, and go to ISSUE.
  - In-range address: cache_addr=addr, cache_data_in=wdata, cache_uop=STR_UOP or LDR_UOP.
  - Out-of-range address (>= DEPTH): cache_uop stays NOP_UOP and an err flag is latched.
- ISSUE, one cycle:
  - The cache performs the access during this cycle: a load updates data_out at the rising edge ending ISSUE; a store writes at the falling edge inside ISSUE.
  - At the end of ISSUE: cache_uop goes to NOP_UOP and state goes to CAPTURE.
- CAPTURE:
  - cache_data_out is valid only from the load rising edge until the next falling edge, when the cache clears it.
  - A falling-edge hold register samples cache_data_out at that falling edge using the pre-update value. This register is not reset.
  - At the rising edge ending CAPTURE: rsp_valid=1, rsp_id=latched ID, rsp_err=err.
  - rsp_data = hold for a load without error, else 0.
  - State returns to IDLE.
- Responses:
  - rsp_valid is high for exactly one cycle. There is no response backpressure.
  - All rsp_* fields hold their values until the next response.
- Throughput and latency:
  - One transaction per 3 cycles.
  - The accept edge is E0. rsp_valid is high in the cycle after E2, at the same time the arbiter is back in IDLE, so the next accept can occur at E3.
- req_ready is 0 outside IDLE. Requesters must hold their request fields stable while req_valid=1 and unaccepted.
- Both requesters valid every cycle: grants strictly alternate. A single valid requester is granted every transaction.
- Only the low 5 bits of cache_addr are meaningful to the cache; the full 32 bits are driven as received.

Test Plan:
- Reset, then r0 store addr=3 data=0xDEADBEEF, then r0 load addr=3:
  - Two responses, rsp_id=0.
  - Load response has rsp_data=0xDEADBEEF and rsp_err=0.
  - Load rsp_valid occurs 3 cycles after the load accept.
- Both requesters valid continuously: r0 loads addr 1, r1 loads addr 2 (preloaded 0x11 / 0x22):
  - Grant order 0,1,0,1.
  - rsp_data alternates 0x11/0x22 with matching rsp_id.
- r1 load addr=40:
  - rsp_err=1, rsp_data=0.
  - cache_uop stays NOP_UOP for the whole transaction.
  - The cache word at addr 8 is unchanged.
- r0 store addr=31 data=0xFFFFFFFF then load addr=31 (boundary):
  - Returns 0xFFFFFFFF.
  - Store response has rsp_data=0 and rsp_err=0.
- Reset asserted during CAPTURE of a load:
  - No rsp_valid.
  - All outputs at reset values on the next cycle.
  - A subsequent load completes normally.
- r1 alone valid after reset:
  - Granted immediately (req_ready[1]=1 in the same cycle).
  - r0 becomes valid during ISSUE and is granted in the next IDLE.
